decode_cond_alu: RTL and testbench

Execute stage of the multi-cycle CPU. It holds three things:
- the instruction decoder, which splits a 16-bit instruction into fields;
- the condition evaluator, which decides whether the instruction executes;
- the ALU, which computes the result and the N/Z/V/C flags.

The register file sits outside this block. It reads registers through the combinational select outputs and writes back through `dest_sel`/`wr_en`.

---
 rtl/decode_cond_alu.sv | 147 ++++++++++++++
 tb/tb_decode_cond_alu.sv | 125 ++++++++++++
 2 files changed

// File: rtl/decode_cond_alu.sv
// Execute stage: instruction decode, condition evaluation, ALU and registered writeback/flags.
// Optional conditional execution is enabled by defining DECODE_COND_EXEC_EN.
module decode_cond_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [2:0]       src1_sel,
    output logic [2:0]       src2_sel,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       dest_sel,
    output logic             wr_en,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR,
        OP_ASR, OP_ROR, OP_MOVA, OP_INC, OP_DEC, OP_NEG, OP_NAND, OP_MOVB
    } op_e;

    logic [1:0] cond;
    op_e        op;
    logic [2:0] dest;
    logic [4:0] sh;

    assign cond     = instr[15:14];
    assign op       = op_e'(instr[13:10]);
    assign dest     = instr[9:7];
    assign src1_sel = instr[6:4];
    assign src2_sel = instr[3:1];
    assign sh       = {1'b0, instr[3:0]};

    // Shared adder: every arithmetic op is x + y + ci, subtraction via ~y + 1
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_ci;
    logic [WIDTH:0]   add_sum;
    logic             add_v;

    always_comb begin
        add_x  = op_a;
        add_y  = op_b;
        add_ci = 1'b0;
        case (op)
            OP_SUB: begin add_y = ~op_b;          add_ci = 1'b1; end
            OP_INC: begin add_y = '0;             add_ci = 1'b1; end
            OP_DEC: begin add_y = ~WIDTH'(1);     add_ci = 1'b1; end
            OP_NEG: begin add_x = '0; add_y = ~op_a; add_ci = 1'b1; end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_ci);
    assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    // Double-width shifts leave the last bit shifted out just beyond the result field
    logic [2*WIDTH-1:0] lsl_ext, lsr_ext, asr_ext, ror_ext;
    logic [31:0]        rot_amt;

    assign lsl_ext = {{WIDTH{1'b0}}, op_a} << sh;
    assign lsr_ext = {op_a, {WIDTH{1'b0}}} >> sh;
    assign asr_ext = $signed({op_a, {WIDTH{1'b0}}}) >>> sh;
    assign rot_amt = {27'b0, sh} % WIDTH;
    assign ror_ext = {op_a, op_a} >> rot_amt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_v;
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_LSL:  begin alu_res = lsl_ext[WIDTH-1:0];       alu_c = lsl_ext[WIDTH];   end
            OP_LSR:  begin alu_res = lsr_ext[2*WIDTH-1:WIDTH]; alu_c = lsr_ext[WIDTH-1]; end
            OP_ASR:  begin alu_res = asr_ext[2*WIDTH-1:WIDTH]; alu_c = asr_ext[WIDTH-1]; end
            OP_ROR:  begin
                alu_res = ror_ext[WIDTH-1:0];
                alu_c   = (sh != 5'd0) && ror_ext[WIDTH-1];
            end
            OP_MOVA: alu_res = op_a;
            OP_NAND: alu_res = ~(op_a & op_b);
            OP_MOVB: alu_res = op_b;
            default: ;
        endcase
    end

    logic cond_ok;

`ifdef DECODE_COND_EXEC_EN
    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            2'b00: cond_ok = 1'b1;
            2'b01: cond_ok = (op_a == op_b);
            2'b10: cond_ok = (op_a != op_b);
            2'b11: cond_ok = ($signed(op_a) < $signed(op_b));
            default: ;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^cond;
    assign cond_ok     = 1'b1;
`endif

    logic exec;
    assign exec = instr_valid && cond_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result   <= '0;
            dest_sel <= '0;
            wr_en    <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
        end else begin
            wr_en <= exec;
            if (exec) begin
                result   <= alu_res;
                dest_sel <= dest;
                negative <= alu_res[WIDTH-1];
                zero     <= (alu_res == '0);
                overflow <= alu_v;
                carry    <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_decode_cond_alu.sv
// Directed self-checking bench for decode_cond_alu; expectations follow DECODE_COND_EXEC_EN.
module tb_decode_cond_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [2:0]  src1_sel, src2_sel, dest_sel;
    logic [15:0] result;
    logic        wr_en, negative, zero, overflow, carry;

    int n_cmp = 0;
    int n_bad = 0;

    decode_cond_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .op_a(op_a), .op_b(op_b), .src1_sel(src1_sel), .src2_sel(src2_sel),
        .result(result), .dest_sel(dest_sel), .wr_en(wr_en),
        .negative(negative), .zero(zero), .overflow(overflow), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // nzvc packs the expected {N, Z, V, C}
    task automatic exp_all(input string tag, input logic wr, input logic [15:0] res,
                           input logic [2:0] dst, input logic [3:0] nzvc);
        chk({tag, "/wr_en"},  16'(wr_en), 16'(wr));
        chk({tag, "/result"}, result, res);
        chk({tag, "/dest"},   16'(dest_sel), 16'(dst));
        chk({tag, "/nzvc"},   16'({negative, zero, overflow, carry}), 16'(nzvc));
    endtask

    task automatic step(input logic v, input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        instr_valid = v;
        instr       = i;
        op_a        = a;
        op_b        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held with a valid instruction presented
        step(1'b1, 16'h0194, 16'h7FFF, 16'h0001);
        exp_all("reset", 1'b0, 16'h0000, 3'd0, 4'b0000);
        chk("src1_sel", 16'(src1_sel), 16'd1);
        chk("src2_sel", 16'(src2_sel), 16'd2);
        rst = 1'b1;

        step(1'b1, 16'h0194, 16'h7FFF, 16'h0001);
        exp_all("add_ovf", 1'b1, 16'h8000, 3'd3, 4'b1010);
        step(1'b1, 16'h0194, 16'hFFFF, 16'h0001);
        exp_all("add_carry", 1'b1, 16'h0000, 3'd3, 4'b0101);

        step(1'b1, 16'h4614, 16'h0005, 16'h0005);
        exp_all("sub_eq", 1'b1, 16'h0000, 3'd4, 4'b0101);
        step(1'b1, 16'h4614, 16'h0005, 16'h0006);
`ifdef DECODE_COND_EXEC_EN
        exp_all("sub_skip", 1'b0, 16'h0000, 3'd4, 4'b0101);
`else
        exp_all("sub_nocond", 1'b1, 16'hFFFF, 3'd4, 4'b1000);
`endif
        step(1'b0, 16'h0194, 16'h1111, 16'h2222);
        chk("idle/wr_en", 16'(wr_en), 16'd0);

        step(1'b1, 16'h18A4, 16'h0F0F, 16'h0000);
        exp_all("lsl", 1'b1, 16'hF0F0, 3'd1, 4'b1000);

        // cond 11, MOV a into r5
        step(1'b1, 16'hEA94, 16'hFFFE, 16'h0001);
        exp_all("slt_take", 1'b1, 16'hFFFE, 3'd5, 4'b1000);
        step(1'b1, 16'hEA94, 16'h0001, 16'hFFFE);
`ifdef DECODE_COND_EXEC_EN
        exp_all("slt_skip", 1'b0, 16'hFFFE, 3'd5, 4'b1000);
`else
        exp_all("slt_nocond", 1'b1, 16'h0001, 3'd5, 4'b0000);
`endif

        step(1'b1, 16'h0614, 16'h8000, 16'h0001);
        exp_all("sub_v", 1'b1, 16'h7FFF, 3'd4, 4'b0011);
        step(1'b1, 16'h2093, 16'h8005, 16'h0000);
        exp_all("asr", 1'b1, 16'hF000, 3'd1, 4'b1001);
        step(1'b1, 16'h2494, 16'h123F, 16'h0000);
        exp_all("ror", 1'b1, 16'hF123, 3'd1, 4'b1001);
        step(1'b1, 16'h1C90, 16'h8001, 16'h0000);
        exp_all("lsr0", 1'b1, 16'h8001, 3'd1, 4'b1000);
        step(1'b1, 16'h3490, 16'h0000, 16'h0000);
        exp_all("neg0", 1'b1, 16'h0000, 3'd1, 4'b0101);
        step(1'b1, 16'h3490, 16'h8000, 16'h0000);
        exp_all("neg_min", 1'b1, 16'h8000, 3'd1, 4'b1010);
        step(1'b1, 16'h3090, 16'h0000, 16'h0000);
        exp_all("dec0", 1'b1, 16'hFFFF, 3'd1, 4'b1000);

        // back-to-back ADDs, one result per clock
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'h0194, 16'(i * 3), 16'd100);
            chk($sformatf("burst%0d/wr_en", i), 16'(wr_en), 16'd1);
            chk($sformatf("burst%0d/result", i), result, 16'(i * 3 + 100));
        end
        step(1'b0, 16'h0194, 16'h0000, 16'h0000);
        chk("burst_end/wr_en", 16'(wr_en), 16'd0);
        chk("burst_end/result", result, 16'd121);

        // asynchronous clear without a clock edge
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_all("async_rst", 1'b0, 16'h0000, 3'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
